// File: rtl/au_pkg.sv
// Shared definitions for the fetch/issue front end and the arithmetic unit:
// opcode values, instruction field positions and the fetch state encoding.
package au_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 5;
    localparam int REG_W   = 5;
    localparam int ISRC_W  = 16;

    // Opcode values
    localparam logic [OPC_W-1:0] OP_MOVSGPR = 5'd0;
    localparam logic [OPC_W-1:0] OP_MOV     = 5'd1;
    localparam logic [OPC_W-1:0] OP_ADD     = 5'd2;
    localparam logic [OPC_W-1:0] OP_SUB     = 5'd3;
    localparam logic [OPC_W-1:0] OP_MUL     = 5'd4;
    localparam logic [OPC_W-1:0] OP_DIV     = 5'd5;
    localparam logic [OPC_W-1:0] OP_HALT    = 5'b11111;

    // Instruction field bit positions (rsrc2 overlaps the top of isrc)
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 27;
    localparam int RDST_MSB     = 26;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_MSB    = 21;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_MSB    = 15;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_MSB     = 15;
    localparam int ISRC_LSB     = 0;

    // Fetch/issue sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // True for every opcode the arithmetic unit understands, HALT included
    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_MOVSGPR, OP_MOV, OP_ADD, OP_SUB,
            OP_MUL, OP_DIV, OP_HALT: legal = 1'b1;
            default:                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Program memory: one write port, one registered read port. A write to the
// address being read returns the new data, so a word loaded in the same
// cycle as the read is seen immediately.
module instr_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port with write-first behaviour on an address collision
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end. Holds the program memory, sequences the
// program counter, skips illegal words, stops on HALT and presents each
// legal instruction (raw and field-decoded) on a valid/ready handshake.
module instr_fetch_issue
    import au_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic                start,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [INSTR_W-1:0]  ir_out,
    output logic [OPC_W-1:0]    opcode_out,
    output logic [REG_W-1:0]    rdst_out,
    output logic [REG_W-1:0]    rsrc1_out,
    output logic                imm_mode_out,
    output logic [REG_W-1:0]    rsrc2_out,
    output logic [ISRC_W-1:0]   isrc_out,
    output logic [PC_W-1:0]     pc_out,
    output logic                busy,
    output logic                halted,
    output logic                illegal
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] w_ir_next;
    logic               r_illegal;
    logic               w_illegal_next;

    logic [INSTR_W-1:0] w_mem_rdata;
    logic [OPC_W-1:0]   w_fetch_op;
    logic               w_prog_en;
    logic               w_stopped;

    // Loading and starting are only allowed while nothing is executing
    assign w_stopped  = (r_state == ST_IDLE) || (r_state == ST_HALTED);
    assign w_prog_en  = prog_we && w_stopped;
    assign w_fetch_op = w_mem_rdata[OPCODE_MSB:OPCODE_LSB];

    // The read address is the next pc, so the word for the FETCH cycle is
    // already sitting in the memory's output register when FETCH begins.
    instr_mem #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (PC_W)
    ) u_instr_mem (
        .clk     (clk),
        .i_we    (w_prog_en),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_pc_next),
        .o_rdata (w_mem_rdata)
    );

    // Next-state, next-pc, instruction register and sticky illegal flag
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ir_next      = r_ir;
        w_illegal_next = r_illegal;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    w_state_next   = ST_FETCH;
                    w_pc_next      = '0;
                    w_illegal_next = 1'b0;
                end
            end
            ST_FETCH: begin
                w_ir_next = w_mem_rdata;
                if (w_fetch_op == OP_HALT) begin
                    w_state_next = ST_HALTED;
                end else if (!is_legal_opcode(w_fetch_op)) begin
                    w_illegal_next = 1'b1;
                    w_pc_next      = r_pc + 1'b1;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    w_pc_next    = r_pc + 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any pending issue and returns to IDLE
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_ir      <= w_ir_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign issue_valid  = (r_state == ST_ISSUE);
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_ISSUE);
    assign halted       = (r_state == ST_HALTED);
    assign illegal      = r_illegal;
    assign pc_out       = r_pc;

    assign ir_out       = r_ir;
    assign opcode_out   = r_ir[OPCODE_MSB:OPCODE_LSB];
    assign rdst_out     = r_ir[RDST_MSB:RDST_LSB];
    assign rsrc1_out    = r_ir[RSRC1_MSB:RSRC1_LSB];
    assign imm_mode_out = r_ir[IMM_MODE_BIT];
    assign rsrc2_out    = r_ir[RSRC2_MSB:RSRC2_LSB];
    assign isrc_out     = r_ir[ISRC_MSB:ISRC_LSB];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed programs, expected issues queued by
// the stimulus and checked by a monitor at each handshake.
`timescale 1ns/1ps
module tb_instr_fetch_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] ir;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        imm;
        logic [4:0]  rs2;
        logic [15:0] isrc;
        int          pc;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    exp_t m_e;
    exp_t m_e4;

    // ---------------- main DUT (64 words) ----------------
    logic        sys_rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic        issue_ready = 1'b0;
    logic        issue_valid;
    logic [31:0] ir_out;
    logic [4:0]  opcode_out, rdst_out, rsrc1_out, rsrc2_out;
    logic        imm_mode_out;
    logic [15:0] isrc_out;
    logic [5:0]  pc_out;
    logic        busy, halted, illegal;

    instr_fetch_issue #(.IMEM_DEPTH(64)) dut (
        .clk(clk), .sys_rst(sys_rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .ir_out(ir_out), .opcode_out(opcode_out),
        .rdst_out(rdst_out), .rsrc1_out(rsrc1_out), .imm_mode_out(imm_mode_out),
        .rsrc2_out(rsrc2_out), .isrc_out(isrc_out), .pc_out(pc_out),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    // ---------------- small DUT (4 words) for pc wrap ----------------
    logic        rst4 = 1'b1;
    logic        we4 = 1'b0;
    logic [1:0]  addr4 = '0;
    logic [31:0] data4 = '0;
    logic        start4 = 1'b0;
    logic        ready4 = 1'b0;
    logic        valid4;
    logic [31:0] ir4;
    logic [4:0]  op4, rd4, rs14, rs24;
    logic        imm4;
    logic [15:0] isrc4;
    logic [1:0]  pc4;
    logic        busy4, halted4, illegal4;

    instr_fetch_issue #(.IMEM_DEPTH(4)) dut4 (
        .clk(clk), .sys_rst(rst4), .prog_we(we4), .prog_addr(addr4),
        .prog_data(data4), .start(start4), .issue_valid(valid4),
        .issue_ready(ready4), .ir_out(ir4), .opcode_out(op4),
        .rdst_out(rd4), .rsrc1_out(rs14), .imm_mode_out(imm4),
        .rsrc2_out(rs24), .isrc_out(isrc4), .pc_out(pc4),
        .busy(busy4), .halted(halted4), .illegal(illegal4)
    );

    // ---------------- helpers ----------------
    function automatic logic [31:0] mkw(input int op, input int rd, input int rs1,
                                        input int imm, input int low);
        return {op[4:0], rd[4:0], rs1[4:0], imm[0], low[15:0]};
    endfunction

    function automatic exp_t mke(input int op, input int rd, input int rs1, input int imm,
                                 input int rs2, input int isrc, input int pc);
        exp_t e;
        e.ir   = mkw(op, rd, rs1, imm, isrc);
        e.op   = op[4:0];
        e.rd   = rd[4:0];
        e.rs1  = rs1[4:0];
        e.imm  = imm[0];
        e.rs2  = rs2[4:0];
        e.isrc = isrc[15:0];
        e.pc   = pc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a[5:0];
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic load4(input int a, input logic [31:0] d);
        we4   = 1'b1;
        addr4 = a[1:0];
        data4 = d;
        tick();
        we4   = 1'b0;
    endtask

    // Returns in the first cycle after start was sampled (the FETCH cycle)
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!sys_rst && issue_valid && issue_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: got pc %0d ir %h, required no issue", pc_out, ir_out);
            end else begin
                m_e = q.pop_front();
                $display("issue pc=%0d ir=%h op=%0d", pc_out, ir_out, opcode_out);
                chk("issue_ir",    ir_out,               m_e.ir);
                chk("issue_op",    32'(opcode_out),      32'(m_e.op));
                chk("issue_rdst",  32'(rdst_out),        32'(m_e.rd));
                chk("issue_rsrc1", 32'(rsrc1_out),       32'(m_e.rs1));
                chk("issue_imm",   32'(imm_mode_out),    32'(m_e.imm));
                chk("issue_rsrc2", 32'(rsrc2_out),       32'(m_e.rs2));
                chk("issue_isrc",  32'(isrc_out),        32'(m_e.isrc));
                chk("issue_pc",    32'(pc_out),          32'(m_e.pc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst4 && valid4 && ready4) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue4: got pc %0d, required no issue", pc4);
            end else begin
                m_e4 = q4.pop_front();
                $display("issue4 pc=%0d ir=%h", pc4, ir4);
                chk("wrap_ir", ir4,       m_e4.ir);
                chk("wrap_pc", 32'(pc4),  32'(m_e4.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] w_mov, w_add, w_sub, w_halt, w_bad, w_div;

    initial begin
        w_mov  = mkw(1, 4, 0, 1, 55);
        w_add  = mkw(2, 2, 0, 0, 16'h0800);
        w_sub  = mkw(3, 1, 3, 0, 16'h2000);
        w_halt = mkw(31, 0, 0, 0, 0);
        w_bad  = mkw(9, 0, 0, 0, 0);
        w_div  = mkw(5, 6, 5, 1, 2);

        // Reset
        tick();
        tick();
        sys_rst = 1'b0;
        rst4    = 1'b0;
        chk("rst_valid",   32'(issue_valid), 32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_halted",  32'(halted),      32'd0);
        chk("rst_illegal", 32'(illegal),     32'd0);
        chk("rst_pc",      32'(pc_out),      32'd0);
        chk("rst_ir",      ir_out,           32'd0);

        // Test 1: MOV, ADD, HALT with ready held high
        issue_ready = 1'b1;
        load(0, w_mov);
        load(1, w_add);
        load(2, w_halt);
        q.push_back(mke(1, 4, 0, 1, 0, 55, 0));
        q.push_back(mke(2, 2, 0, 0, 1, 16'h0800, 1));
        pulse_start();
        chk("t1_c1_valid", 32'(issue_valid), 32'd0);
        chk("t1_c1_busy",  32'(busy),        32'd1);
        tick();
        chk("t1_c2_valid", 32'(issue_valid), 32'd1);
        tick();
        chk("t1_c3_valid", 32'(issue_valid), 32'd0);
        tick();
        chk("t1_c4_valid", 32'(issue_valid), 32'd1);
        tick();
        chk("t1_c5_valid",  32'(issue_valid), 32'd0);
        chk("t1_c5_halted", 32'(halted),      32'd0);
        tick();
        chk("t1_c6_halted", 32'(halted),      32'd1);
        chk("t1_c6_busy",   32'(busy),        32'd0);
        chk("t1_c6_valid",  32'(issue_valid), 32'd0);

        // Test 2: ten-cycle stall on SUB
        issue_ready = 1'b0;
        load(0, w_sub);
        load(1, w_halt);
        pulse_start();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t2_stall_valid", 32'(issue_valid), 32'd1);
            chk("t2_stall_pc",    32'(pc_out),      32'd0);
            chk("t2_stall_ir",    ir_out,           w_sub);
            chk("t2_stall_rsrc1", 32'(rsrc1_out),   32'd3);
            chk("t2_stall_rsrc2", 32'(rsrc2_out),   32'd4);
            tick();
        end
        q.push_back(mke(3, 1, 3, 0, 4, 16'h2000, 0));
        issue_ready = 1'b1;
        tick();
        chk("t2_after_valid", 32'(issue_valid), 32'd0);
        tick();
        chk("t2_halted", 32'(halted), 32'd1);

        // Test 3: illegal word skipped, DIV issued from pc 1
        load(0, w_bad);
        load(1, w_div);
        load(2, w_halt);
        q.push_back(mke(5, 6, 5, 1, 0, 2, 1));
        pulse_start();
        chk("t3_c1_illegal", 32'(illegal), 32'd0);
        tick();
        chk("t3_c2_illegal", 32'(illegal),     32'd1);
        chk("t3_c2_valid",   32'(issue_valid), 32'd0);
        chk("t3_c2_pc",      32'(pc_out),      32'd1);
        tick();
        chk("t3_c3_valid", 32'(issue_valid), 32'd1);
        tick();
        tick();
        chk("t3_halted",        32'(halted),  32'd1);
        chk("t3_illegal_stays", 32'(illegal), 32'd1);

        // Test 4: reset during a stalled ISSUE, then reload works
        load(0, w_mov);
        load(1, w_sub);
        q.push_back(mke(1, 4, 0, 1, 0, 55, 0));
        pulse_start();
        chk("t4_illegal_cleared", 32'(illegal), 32'd0);
        tick();
        tick();
        issue_ready = 1'b0;
        tick();
        chk("t4_stall_valid", 32'(issue_valid), 32'd1);
        chk("t4_stall_pc",    32'(pc_out),      32'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t4_rst_valid",  32'(issue_valid), 32'd0);
        chk("t4_rst_pc",     32'(pc_out),      32'd0);
        chk("t4_rst_busy",   32'(busy),        32'd0);
        chk("t4_rst_halted", 32'(halted),      32'd0);
        load(0, w_add);
        load(1, w_halt);
        q.push_back(mke(2, 2, 0, 0, 1, 16'h0800, 0));
        issue_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        tick();
        chk("t4_rerun_halted", 32'(halted), 32'd1);

        // Test 5: prog_we and start ignored during ISSUE
        issue_ready = 1'b0;
        q.push_back(mke(2, 2, 0, 0, 1, 16'h0800, 0));
        pulse_start();
        tick();
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = w_sub;
        start     = 1'b1;
        tick();
        prog_addr = 6'd1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        chk("t5_still_valid", 32'(issue_valid), 32'd1);
        chk("t5_still_ir",    ir_out,           w_add);
        issue_ready = 1'b1;
        tick();
        tick();
        chk("t5_halted", 32'(halted), 32'd1);
        q.push_back(mke(2, 2, 0, 0, 1, 16'h0800, 0));
        pulse_start();
        tick();
        tick();
        tick();
        chk("t5_rerun_halted", 32'(halted), 32'd1);

        // Test 6: write and start in the same cycle
        q.push_back(mke(1, 4, 0, 1, 0, 55, 0));
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = w_mov;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_halted", 32'(halted), 32'd1);

        // Test 7: 4-word memory, pc wraps 3 -> 0
        for (int i = 0; i < 4; i++) begin
            load4(i, mkw(1, 4, 0, 1, 10 + i));
        end
        for (int k = 0; k < 6; k++) begin
            q4.push_back(mke(1, 4, 0, 1, 0, 10 + (k % 4), k % 4));
        end
        ready4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int n = 0; n < 40 && q4.size() > 0; n++) begin
            tick();
        end
        ready4 = 1'b0;
        chk("t7_drained", 32'(q4.size()), 32'd0);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("t7_rst_pc",    32'(pc4),    32'd0);
        chk("t7_rst_valid", 32'(valid4), 32'd0);

        tick();
        tick();
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_issue.md
# instr_fetch_issue

Front-end stage that feeds the arithmetic unit. It holds a small program memory of 32-bit instructions and runs a program counter and fetch/issue state machine. Each fetched word is decoded into the fields the arithmetic unit consumes (opcode, rdst, rsrc1, imm_mode, rsrc2, isrc), and the instruction is presented through a valid/ready handshake. It stops on a HALT opcode.

## Interface
- IMEM_DEPTH, 64, number of 32-bit instruction words; power of two, ≥ 2
- PC_W, $clog2(IMEM_DEPTH), program-counter width
- clk  in  1  sole clock, rising-edge
- sys_rst  in  1  synchronous, active-high reset
- prog_we  in  1  program-memory write strobe; honoured only in IDLE or HALTED
- prog_addr  in  PC_W  program-memory write address
- prog_data  in  32  program-memory write data
- start  in  1  begin execution from pc = 0; honoured only in IDLE or HALTED
- issue_valid  out  1  decoded instruction on outputs is valid
- issue_ready  in  1  downstream accepts the instruction this cycle
- ir_out  out  32  raw instruction word
- opcode_out  out  5  ir_out[31:27]
- rdst_out  out  5  ir_out[26:22]
- rsrc1_out  out  5  ir_out[21:17]
- imm_mode_out  out  1  ir_out[16]
- rsrc2_out  out  5  ir_out[15:11]
- isrc_out  out  16  ir_out[15:0]
- pc_out  out  PC_W  address of the instruction in ir_out
- busy  out  1  state is FETCH or ISSUE
- halted  out  1  state is HALTED
- illegal  out  1  sticky: an undefined opcode was fetched

## Operation
- Legal opcodes: MOVSGPR 0, MOV 1, ADD 2, SUB 3, MUL 4, DIV 5, HALT 31. Opcodes 6–30 are illegal.
- States: IDLE, FETCH, ISSUE, HALTED.
- **IDLE**
  - prog_we writes prog_data to mem[prog_addr].
  - start: pc ← 0, illegal ← 0, go to FETCH.
  - If prog_we and start are high in the same cycle, the write happens and then execution starts. The write lands before the first fetch.
- **FETCH**
  - Synchronous read of mem[pc]; the word is registered into IR at the end of the cycle.
  - Next state depends on the fetched opcode:
    - HALT → HALTED; no issue.
    - Illegal → illegal ← 1, pc ← pc+1, stay in FETCH; no issue.
    - Legal → ISSUE.
- **ISSUE**
  - issue_valid = 1. IR and all decoded outputs are held stable until accepted.
  - On issue_valid & issue_ready: pc ← pc+1, go to FETCH.
- **HALTED**
  - Same rules as IDLE: prog_we is honoured; start restarts from pc 0.
  - halted = 1.
- pc increments modulo IMEM_DEPTH, so IMEM_DEPTH−1 wraps to 0.
- prog_we and start are ignored while in FETCH or ISSUE.
- Decoded outputs are pure slices of IR; no extension or arithmetic is applied.

## Timing
- All outputs are registered or derived directly from registered state.
- Reset values:
  - state = IDLE, pc = 0, IR = 0
  - issue_valid = 0, busy = 0, halted = 0, illegal = 0
  - Memory contents are not reset.
- start sampled at edge N → FETCH during cycle N+1 → issue_valid first high in cycle N+2.
- With issue_ready held high, one instruction is issued every 2 cycles.
- When issue_ready is low, the stall can be arbitrarily long with no loss or duplication of instructions.
- issue_valid never drops without a handshake, except on sys_rst.
- An illegal word costs 1 cycle. HALT reaches HALTED one cycle after its FETCH.
- sys_rst mid-operation returns the block to IDLE on the next edge. Any pending issue is discarded.

## Structure
- Shared package `au_pkg`:
  - opcode constants (including HALT = 5'b11111)
  - instruction field bit positions
  - the state enum
- The AU uses the same field-position constants from this package.
- One sub-module, `instr_mem`: IMEM_DEPTH×32 memory with synchronous write and synchronous read, one write port and one read port.

## Test plan
- Load mem[0..2] = MOV imm r4←55, ADD r2=r0+r1, HALT. start, issue_ready=1:
  - issue_valid at cycle +2 with opcode 1, rdst 4, isrc 55, pc 0
  - then cycle +4 with opcode 2, pc 1
  - halted at cycle +6; issue_valid is never asserted for the HALT word.
- Hold issue_ready=0 for 10 cycles during ISSUE of SUB (opcode 3, rsrc1 3, rsrc2 4):
  - outputs stable, pc unchanged
  - accepted exactly once after ready rises.
- mem[0] = opcode 9, mem[1] = DIV imm isrc 2:
  - illegal goes to 1 and stays
  - the first issue is DIV at pc 1.
- IMEM_DEPTH=4, no HALT in mem:
  - pc sequence 0,1,2,3,0,1
- sys_rst asserted during a stalled ISSUE:
  - next cycle issue_valid=0, pc=0, state IDLE
  - prog_we then writes successfully.
- prog_we pulsed during ISSUE:
  - memory unchanged, verified by a later re-run from start.
